// File: rtl/instruction_queue_pkg.sv
// Shared instruction definitions: opcode and operand-interpretation enums
// plus the opcode legality helper used by the instruction queue.
package instruction_queue_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MULT = 4'd2,
    DIV  = 4'd3,
    SL   = 4'd4,
    SR   = 4'd5
  } op_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } operand_type_t;

  // Encodings above SR are reserved and never enter the queue.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= 4'(SR));
  endfunction

endpackage

// File: rtl/instruction_queue.sv
// Circular instruction FIFO: one storage array, wrap-around read/write
// pointers and an occupancy counter; illegal opcodes are consumed, not stored.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  op_t                      opcode,
  input  operand_type_t            op_type,
  input  logic [DATA_W-1:0]        op_a,
  input  logic [DATA_W-1:0]        op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output op_t                      out_opcode,
  output operand_type_t            out_op_type,
  output logic [DATA_W-1:0]        out_op_a,
  output logic [DATA_W-1:0]        out_op_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    op_t               opcode;
    operand_type_t     op_type;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{opcode: ADD, op_type: UNSIGNED, op_a: '0, op_b: '0};

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push_hs;
  logic             op_legal;
  logic             do_store;
  logic             do_pop;
  entry_t           entry_in;
  entry_t           head;

  // Handshake: a transfer happens on a posedge where valid && ready are both
  // high and flush is low; ready never depends on valid, and an illegal
  // opcode still completes its handshake but is dropped instead of stored.
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign op_legal = is_legal_op(opcode);
  assign push_hs  = in_valid && in_ready && !flush;
  assign do_store = push_hs && op_legal;
  assign do_pop   = out_valid && out_ready && !flush;

  assign entry_in = '{opcode: opcode, op_type: op_type, op_a: op_a, op_b: op_b};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_store) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({do_store, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_hs && !op_legal) err_illegal <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the head mux hides it while empty.
  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= entry_in;
  end

  always_comb begin
    head = EMPTY_ENTRY;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_opcode  = head.opcode;
  assign out_op_type = head.op_type;
  assign out_op_a    = head.op_a;
  assign out_op_b    = head.op_b;

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue (DEPTH=4, DATA_W=16): vector table plus
// hand-written corner sequences, checked against a queue-based scoreboard.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int EW    = 4 + 1 + 2 * DW;

  logic              clk;
  logic              rstN;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  op_t               opcode;
  operand_type_t     op_type;
  logic [DW-1:0]     op_a;
  logic [DW-1:0]     op_b;
  logic              out_valid;
  logic              out_ready;
  op_t               out_opcode;
  operand_type_t     out_op_type;
  logic [DW-1:0]     out_op_a;
  logic [DW-1:0]     out_op_b;
  logic [$clog2(DEPTH):0] count;
  logic              err_illegal;

  logic [EW-1:0] exp_q[$];
  logic          merr;
  int            checks;
  int            errors;

  instruction_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op_type(op_type), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op_type(out_op_type),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .count(count), .err_illegal(err_illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    op_t           opcode;
    operand_type_t op_type;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_ready;
    logic          flush;
    int            exp_count;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input op_t op, input operand_type_t t,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic r, input logic f);
    in_valid  = v;
    opcode    = op;
    op_type   = t;
    op_a      = a;
    op_b      = b;
    out_ready = r;
    flush     = f;
  endtask

  task automatic idle();
    drive(1'b0, ADD, UNSIGNED, '0, '0, 1'b0, 1'b0);
  endtask

  // Checks pre-edge outputs against the scoreboard, updates it, then clocks.
  task automatic tick();
    logic [EW-1:0] head_exp;
    int n;
    n = exp_q.size();
    head_exp = (n != 0) ? exp_q[0] : {ADD, UNSIGNED, 16'h0, 16'h0};
    chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("head", 64'({out_opcode, out_op_type, out_op_a, out_op_b}), 64'(head_exp));
    if (flush) begin
      exp_q.delete();
      merr = 1'b0;
    end else begin
      if (out_ready && n != 0) void'(exp_q.pop_front());
      if (in_valid && n < DEPTH) begin
        if (is_legal_op(opcode)) exp_q.push_back({opcode, op_type, op_a, op_b});
        else merr = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("err_illegal", 64'(err_illegal), 64'(merr));
  endtask

  task automatic push_rand(input logic r);
    drive(1'b1, op_t'($urandom_range(0, 5)), operand_type_t'($urandom_range(0, 1)),
          DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)), r, 1'b0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    merr   = 1'b0;
    idle();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_opcode", 64'(out_opcode), 64'(ADD));
    rstN = 1'b1;
    @(negedge clk);

    // Fill to full, try a fifth push, drain, then pop while empty.
    tbl[0] = '{1'b1, SUB,  SIGNED,   16'h8001, 16'h0002, 1'b0, 1'b0, 1};
    tbl[1] = '{1'b1, ADD,  UNSIGNED, 16'h00FF, 16'h0001, 1'b0, 1'b0, 2};
    tbl[2] = '{1'b1, MULT, SIGNED,   16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 3};
    tbl[3] = '{1'b1, SR,   UNSIGNED, 16'h1234, 16'h0004, 1'b0, 1'b0, 4};
    tbl[4] = '{1'b1, DIV,  SIGNED,   16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 4};
    tbl[5] = '{1'b0, ADD,  UNSIGNED, 16'h0000, 16'h0000, 1'b1, 1'b0, 3};
    tbl[6] = '{1'b0, ADD,  UNSIGNED, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    tbl[7] = '{1'b0, ADD,  UNSIGNED, 16'h0000, 16'h0000, 1'b1, 1'b0, 1};
    tbl[8] = '{1'b0, ADD,  UNSIGNED, 16'h0000, 16'h0000, 1'b1, 1'b0, 0};
    tbl[9] = '{1'b0, ADD,  UNSIGNED, 16'h0000, 16'h0000, 1'b1, 1'b0, 0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].in_valid, tbl[i].opcode, tbl[i].op_type, tbl[i].a, tbl[i].b,
            tbl[i].out_ready, tbl[i].flush);
      if (i == 4) chk("full_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
    end

    // Hold at 3 entries while pushing and popping together across the wrap.
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    for (int i = 0; i < 6; i++) begin
      push_rand(1'b1);
      chk("steady_count", 64'(count), 64'd3);
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Reserved opcode: handshaken, dropped, sticky error until flush.
    drive(1'b1, op_t'(4'hF), SIGNED, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    chk("illegal_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("illegal_count", 64'(count), 64'd0);
    chk("illegal_err", 64'(err_illegal), 64'd1);
    push_rand(1'b0);
    idle();
    tick();
    chk("err_sticky", 64'(err_illegal), 64'd1);
    idle();
    flush = 1'b1;
    tick();
    chk("flush_err", 64'(err_illegal), 64'd0);

    // Flush competing with push and pop at count 2, with error set.
    push_rand(1'b0);
    push_rand(1'b0);
    drive(1'b1, op_t'(4'hC), UNSIGNED, 16'h0101, 16'h0202, 1'b0, 1'b0);
    tick();
    drive(1'b1, SL, UNSIGNED, 16'h0303, 16'h0404, 1'b1, 1'b1);
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_err2", 64'(err_illegal), 64'd0);

    // Asynchronous reset with 3 entries queued.
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    idle();
    #2 rstN = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_opcode", 64'(out_opcode), 64'(ADD));
    chk("arst_op_a", 64'(out_op_a), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    exp_q.delete();
    merr = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    drive(1'b1, DIV, SIGNED, 16'hC0DE, 16'h0009, 1'b0, 1'b0);
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_op_a", 64'(out_op_a), 64'hC0DE);
    idle();
    out_ready = 1'b1;
    tick();
    tick();
    chk("empty_pop_count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
